// File: rtl/regfile_pkg.sv
// Shared widths and arbiter state encoding for the register-file
// writeback arbiter.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 8;

    localparam logic [0:0] LAST_A = 1'b0;
    localparam logic [0:0] LAST_B = 1'b1;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Write-to-read bypass for one read port; x0 is never forwarded.
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit FWD_EN = 1'b0
) (
    input  logic              writereg,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] fwd_data
);

    logic hit;

    assign hit = FWD_EN && writereg && (rd == rs) && (rs != '0);
    assign fwd_data = hit ? writedata : readdata;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with alternating priority on conflict.
// Define REGFILE_WB_FWD_EN to bypass the pending write onto the read data.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              writereg,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] readdata1,
    input  logic [DATA_W-1:0] readdata2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CNT_W-1:0]  conflict_cnt
);

`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [0:0] state;
    logic       a_xfer;
    logic       b_xfer;

    // Reset gates the grants so nothing handshakes while held in reset.
    assign a_ready = reset & a_valid & (~b_valid | (state == LAST_B));
    assign b_ready = reset & b_valid & (~a_valid | (state == LAST_A));
    assign a_xfer  = a_valid & a_ready;
    assign b_xfer  = b_valid & b_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= LAST_B;
            writereg  <= 1'b0;
            rd        <= '0;
            writedata <= '0;
        end else begin
            writereg <= 1'b0;
            if (a_xfer) begin
                state     <= LAST_A;
                writereg  <= (a_rd != '0);
                rd        <= a_rd;
                writedata <= a_data;
            end else if (b_xfer) begin
                state     <= LAST_B;
                writereg  <= (b_rd != '0);
                rd        <= b_rd;
                writedata <= b_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    regfile_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_EN (FWD_EN)
    ) u_fwd1 (
        .writereg  (writereg),
        .rd        (rd),
        .rs        (rs1),
        .writedata (writedata),
        .readdata  (readdata1),
        .fwd_data  (fwd_data1)
    );

    regfile_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_EN (FWD_EN)
    ) u_fwd2 (
        .writereg  (writereg),
        .rd        (rd),
        .rs        (rs2),
        .writedata (writedata),
        .readdata  (readdata2),
        .fwd_data  (fwd_data2)
    );

endmodule
